// File: rtl/gnr_node_multi.sv
// gnr_node_multi: NCH independent copies of a gene-regulatory-network node.
// Each channel registers a W-bit state, commits a candidate next value once
// every DIV accepted enables, reports value changes as a one-cycle pulse and
// raises a per-channel stable flag after STABLE_N consecutive unchanged commits.
module gnr_node_multi #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned W        = 1,
  parameter int unsigned DIV      = 2,
  parameter int unsigned STABLE_N = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               reset_nos,
  input  logic [W-1:0]       init_state,
  input  logic [NCH-1:0]     start_s,
  input  logic [NCH*W-1:0]   next_s,
  output logic [NCH*W-1:0]   s,
  output logic [NCH*W-1:0]   node_out,
  output logic [NCH-1:0]     changed,
  output logic [NCH-1:0]     stable,
  output logic               all_stable
);

  localparam int unsigned PHW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SCW = $clog2(STABLE_N + 1);

  localparam logic [PHW-1:0] PH_LAST = PHW'(DIV - 1);
  localparam logic [SCW-1:0] SC_MAX  = SCW'(STABLE_N);

  logic [NCH-1:0][W-1:0]   nx;
  logic [NCH-1:0][W-1:0]   s_q, s_d;
  logic [NCH-1:0][PHW-1:0] ph_q, ph_d;
  logic [NCH-1:0][SCW-1:0] sc_q, sc_d;
  logic [NCH-1:0]          changed_q, changed_d;
  logic [NCH-1:0]          stable_q, stable_d;

  assign nx = next_s;

  // Per-channel next state: reset_nos reload beats an accepted enable; a
  // commit happens only when the phase counter has reached DIV-1.
  always_comb begin
    s_d       = s_q;
    ph_d      = ph_q;
    sc_d      = sc_q;
    stable_d  = stable_q;
    changed_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (reset_nos) begin
        // Phase preloaded to DIV-1 so the first enable afterwards commits;
        // any partial phase count is discarded here.
        s_d[i]  = init_state;
        ph_d[i] = PH_LAST;
      end else if (start && start_s[i]) begin
        if (ph_q[i] == PH_LAST) begin
          s_d[i]  = nx[i];
          ph_d[i] = '0;
          if (nx[i] != s_q[i]) begin
            changed_d[i] = 1'b1;
            sc_d[i]      = '0;
          end else if (sc_q[i] != SC_MAX) begin
            sc_d[i] = sc_q[i] + SCW'(1);
          end
          stable_d[i] = (sc_d[i] == SC_MAX);
        end else begin
          ph_d[i] = ph_q[i] + PHW'(1);
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q       <= '0;
      ph_q      <= '0;
      sc_q      <= '0;
      changed_q <= '0;
      stable_q  <= '0;
    end else begin
      s_q       <= s_d;
      ph_q      <= ph_d;
      sc_q      <= sc_d;
      changed_q <= changed_d;
      stable_q  <= stable_d;
    end
  end

  assign s          = s_q;
  assign node_out   = s_q;
  assign changed    = changed_q;
  assign stable     = stable_q;
  assign all_stable = &stable_q;

endmodule

// File: tb/tb_gnr_node_multi.sv
// Directed testbench for gnr_node_multi: three instances cover the default
// boolean node, a 4-bit node with DIV=3, and a DIV=1 single-channel node.
module tb_gnr_node_multi;

  logic clk = 1'b0;
  logic rst, start;
  always #5 clk = ~clk;

  // Instance A: NCH=2, W=1, DIV=2, STABLE_N=4
  logic       rn_a;
  logic [0:0] init_a;
  logic [1:0] ss_a, nx_a, s_a, no_a, ch_a, st_a;
  logic       as_a;

  // Instance B: NCH=2, W=4, DIV=3, STABLE_N=4
  logic       rn_b;
  logic [3:0] init_b;
  logic [1:0] ss_b, ch_b, st_b;
  logic [7:0] nx_b, s_b, no_b;
  logic       as_b;

  // Instance C: NCH=1, W=2, DIV=1, STABLE_N=2
  logic       rn_c;
  logic [1:0] init_c;
  logic [0:0] ss_c, ch_c, st_c;
  logic [1:0] nx_c, s_c, no_c;
  logic       as_c;

  int n_vec = 0;
  int n_err = 0;

  gnr_node_multi #(.NCH(2), .W(1), .DIV(2), .STABLE_N(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .reset_nos(rn_a), .init_state(init_a),
    .start_s(ss_a), .next_s(nx_a), .s(s_a), .node_out(no_a), .changed(ch_a),
    .stable(st_a), .all_stable(as_a));

  gnr_node_multi #(.NCH(2), .W(4), .DIV(3), .STABLE_N(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .reset_nos(rn_b), .init_state(init_b),
    .start_s(ss_b), .next_s(nx_b), .s(s_b), .node_out(no_b), .changed(ch_b),
    .stable(st_b), .all_stable(as_b));

  gnr_node_multi #(.NCH(1), .W(2), .DIV(1), .STABLE_N(2)) dut_c (
    .clk(clk), .rst(rst), .start(start), .reset_nos(rn_c), .init_state(init_c),
    .start_s(ss_c), .next_s(nx_c), .s(s_c), .node_out(no_c), .changed(ch_c),
    .stable(st_c), .all_stable(as_c));

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    rn_a = 1'b0; init_a = '0; ss_a = '0; nx_a = '0;
    rn_b = 1'b0; init_b = '0; ss_b = '0; nx_b = '0;
    rn_c = 1'b0; init_c = '0; ss_c = '0; nx_c = '0;

    // Plain reset
    tick(2);
    chk("rst_s_a", s_a, 0);
    chk("rst_chg_a", ch_a, 0);
    chk("rst_stb_a", st_a, 0);
    chk("rst_all_a", as_a, 0);
    chk("rst_s_b", s_b, 0);
    chk("rst_s_c", s_c, 0);

    // rst overrides reset_nos and enables in the same cycle
    rn_a = 1'b1; init_a = 1'b1; rn_b = 1'b1; init_b = 4'h5;
    start = 1'b1; ss_a = 2'b11; nx_a = 2'b11; ss_b = 2'b11; nx_b = 8'hff;
    ss_c = 1'b1; nx_c = 2'd3;
    tick(1);
    chk("rstov_s_a", s_a, 0);
    chk("rstov_chg_a", ch_a, 0);
    chk("rstov_all_a", as_a, 0);
    chk("rstov_s_b", s_b, 0);
    chk("rstov_s_c", s_c, 0);
    chk("rstov_chg_c", ch_c, 0);

    rst = 1'b0; rn_a = 1'b0; rn_b = 1'b0;
    ss_a = '0; ss_b = '0; ss_c = '0;

    // DIV=2: first enable only advances the phase, second commits
    ss_a = 2'b01; nx_a = 2'b01;
    tick(1);
    chk("div2_e1_s", s_a, 2'b00);
    chk("div2_e1_chg", ch_a, 2'b00);
    tick(1);
    chk("div2_e2_s", s_a, 2'b01);
    chk("div2_e2_chg", ch_a, 2'b01);
    chk("div2_nodeout", no_a, 2'b01);
    ss_a = '0;
    tick(1);
    chk("div2_pulse_end", ch_a, 2'b00);
    chk("div2_hold_s", s_a, 2'b01);

    // DIV=1: one-cycle latency, STABLE_N=2
    ss_c = 1'b1; nx_c = 2'd2;
    tick(1);
    chk("div1_s", s_c, 2'd2);
    chk("div1_chg", ch_c, 1'b1);
    chk("div1_stb0", st_c, 1'b0);
    tick(1);
    chk("div1_chg_off", ch_c, 1'b0);
    chk("div1_stb1", st_c, 1'b0);
    tick(1);
    chk("div1_stb2", st_c, 1'b1);
    chk("div1_all", as_c, 1'b1);
    ss_c = '0;

    // Stability on A ch0: four equal commits (8 enables at DIV=2)
    ss_a = 2'b01; nx_a = 2'b01;
    tick(6);
    chk("stb_after3", st_a, 2'b00);
    tick(2);
    chk("stb_after4", st_a, 2'b01);
    chk("stb_all", as_a, 1'b0);
    chk("stb_nochg", ch_a, 2'b00);
    nx_a = 2'b00;
    tick(1);
    chk("stb_noncommit", st_a, 2'b01);
    chk("stb_noncommit_s", s_a, 2'b01);
    tick(1);
    chk("stb_diff_s", s_a, 2'b00);
    chk("stb_diff_chg", ch_a, 2'b01);
    chk("stb_diff_stb", st_a, 2'b00);
    ss_a = '0;

    // reset_nos then one enable commits immediately
    rn_a = 1'b1; init_a = 1'b1;
    tick(1);
    chk("rnos_s", s_a, 2'b11);
    chk("rnos_chg", ch_a, 2'b00);
    rn_a = 1'b0; ss_a = 2'b01; nx_a = 2'b00;
    tick(1);
    chk("rnos_e1_s", s_a, 2'b10);
    chk("rnos_e1_chg", ch_a, 2'b01);
    ss_a = '0;

    // DIV=3 on B: partial phase discarded by reset_nos, commits on enables 1 and 4
    ss_b = 2'b01; nx_b = 8'h0a;
    tick(1);
    chk("d3_partial_s", s_b, 8'h00);
    rn_b = 1'b1; init_b = 4'h5;
    tick(1);
    chk("d3_rnos_s", s_b, 8'h55);
    chk("d3_rnos_chg", ch_b, 2'b00);
    rn_b = 1'b0; nx_b = 8'h09;
    tick(1);
    chk("d3_e1_s", s_b, 8'h59);
    chk("d3_e1_chg", ch_b, 2'b01);
    nx_b = 8'h03;
    tick(1);
    chk("d3_e2_s", s_b, 8'h59);
    tick(1);
    chk("d3_e3_s", s_b, 8'h59);
    tick(1);
    chk("d3_e4_s", s_b, 8'h53);
    chk("d3_e4_chg", ch_b, 2'b01);
    ss_b = '0;

    // start=0 freezes everything despite enables
    start = 1'b0;
    ss_a = 2'b11; nx_a = 2'b01; ss_b = 2'b11; nx_b = 8'h00; ss_c = 1'b1; nx_c = 2'd3;
    tick(10);
    chk("gate_s_a", s_a, 2'b10);
    chk("gate_chg_a", ch_a, 2'b00);
    chk("gate_s_b", s_b, 8'h53);
    chk("gate_s_c", s_c, 2'd2);
    chk("gate_stb_c", st_c, 1'b1);
    chk("gate_chg_c", ch_c, 1'b0);

    // Phases survived the gate: ch1 was at DIV-1, ch0 at 0
    start = 1'b1; ss_b = '0; ss_c = '0;
    tick(1);
    chk("ph_hold_e1_s", s_a, 2'b00);
    chk("ph_hold_e1_chg", ch_a, 2'b10);
    tick(1);
    chk("ph_hold_e2_s", s_a, 2'b01);
    chk("ph_hold_e2_chg", ch_a, 2'b01);

    // reset_nos still acts while start=0
    start = 1'b0; rn_a = 1'b1; init_a = 1'b1;
    tick(1);
    chk("gate_rnos_s", s_a, 2'b11);
    rn_a = 1'b0;
    tick(1);
    chk("gate_rnos_hold", s_a, 2'b11);

    // all_stable needs every channel at STABLE_N
    rst = 1'b1; ss_a = '0;
    tick(1);
    rst = 1'b0; start = 1'b1; ss_a = 2'b01; nx_a = 2'b00;
    tick(8);
    chk("all_ch0_stb", st_a, 2'b01);
    chk("all_ch0_all", as_a, 1'b0);
    ss_a = 2'b10;
    tick(7);
    chk("all_ch1_pre", as_a, 1'b0);
    tick(1);
    chk("all_ch1_stb", st_a, 2'b11);
    chk("all_ch1_all", as_a, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
